// File: rtl/if_id_hazard_stage_pkg.sv
// Shared definitions for the IF/ID stage: FSM encoding, the flushed encoding,
// and helpers that pull the rs/rt register fields out of an instruction.
package if_id_hazard_stage_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam int          REG_W  = 5;
  localparam int          RS_LSB = 21;
  localparam int          RT_LSB = 16;

  function automatic logic [REG_W-1:0] rs_of(input logic [31:0] instr);
    return instr[RS_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rt_of(input logic [31:0] instr);
    return instr[RT_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/if_id_hazard_stage_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use stall, branch flush and bubble
// request for ID/EX, plus saturating stall/flush performance counters.
module if_id_hazard_stage
  import if_id_hazard_stage_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      IF_Instruction,
  input  logic [31:0]      IF_PCResult,
  input  logic             IF_Valid,
  input  logic [1:0]       EX_MemRead,
  input  logic [31:0]      EX_Instruction,
  input  logic             FlushIn,
  output logic [31:0]      ID_Instruction,
  output logic [31:0]      ID_PCResult,
  output logic             ID_Valid,
  output logic             PCWrite,
  output logic             Bubble,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int CW = $clog2(LOAD_STALL_CYCLES + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [REG_W-1:0] ex_rt;
  logic            hazard;
  logic            stall;

  assign ex_rt  = rt_of(EX_Instruction);
  assign hazard = ID_Valid && (EX_MemRead != 2'b00) && (ex_rt != '0) &&
                  ((ex_rt == rs_of(ID_Instruction)) || (ex_rt == rt_of(ID_Instruction)));
  assign stall  = (state == STALL) || ((state == RUN) && hazard);

  // NOTE: the enables are gated by Rst_n so the PC keeps running and no bubble
  // is requested while reset is asserted, even if FlushIn toggles meanwhile.
  assign PCWrite = !Rst_n || FlushIn || !stall;
  assign Bubble  = Rst_n && (FlushIn || stall);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ID_Instruction <= NOP;
      ID_PCResult    <= '0;
      ID_Valid       <= 1'b0;
      state          <= RUN;
      cnt            <= '0;
    end else if (FlushIn) begin
      ID_Instruction <= NOP;
      ID_PCResult    <= '0;
      ID_Valid       <= 1'b0;
      state          <= RUN;
      cnt            <= '0;
    end else if (stall) begin
      // ID registers hold; only the stall sequencer advances.
      if (state == RUN) begin
        if (LOAD_STALL_CYCLES > 1) begin
          state <= STALL;
          cnt   <= CW'(LOAD_STALL_CYCLES - 1);
        end
      end else begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= RUN;
      end
    end else begin
      ID_Instruction <= IF_Instruction;
      ID_PCResult    <= IF_PCResult;
      ID_Valid       <= IF_Valid;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (stall && !FlushIn),
    .count (StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (FlushIn),
    .count (FlushCount)
  );

endmodule
